// File: rtl/sram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sram_arbiter_pkg
// Purpose : Definitions shared by the SRAM arbiter and its winner-select block:
//           the FSM state encoding, the owner encoding and the default address
//           width.
// Contents: state_t     - IDLE / ADDR / DATA transaction phases
//           OWN_INST    - owner code for the instruction-fetch port
//           OWN_DATA    - owner code for the load/store port
//           AW_DEFAULT  - default address width
// -----------------------------------------------------------------------------
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam int AW_DEFAULT = 32;

endpackage

// File: rtl/sram_arbiter_pick.sv
// -----------------------------------------------------------------------------
// sram_arb_pick
// Purpose : Combinational winner select between the fetch and load/store
//           requesters.
// Config  : SRAM_ARB_RR_EN defined   -> round-robin on simultaneous requests
//                                       (winner is the side not granted last).
//           SRAM_ARB_RR_EN undefined -> fixed priority, data beats inst.
// Ports   : i_inst_req    - fetch request
//           i_data_req    - load/store request
//           i_last_grant  - owner of the previous grant (round-robin build only)
//           o_grant_vld   - at least one requester is asking
//           o_grant_owner - winning owner (OWN_INST / OWN_DATA)
// -----------------------------------------------------------------------------
module sram_arb_pick
  import sram_arbiter_pkg::*;
(
  input  logic i_inst_req,
  input  logic i_data_req,
`ifdef SRAM_ARB_RR_EN
  input  logic i_last_grant,
`endif
  output logic o_grant_vld,
  output logic o_grant_owner
);

  always_comb begin
    o_grant_vld   = i_inst_req | i_data_req;
    o_grant_owner = OWN_INST;
`ifdef SRAM_ARB_RR_EN
    if (i_inst_req && i_data_req) begin
      o_grant_owner = (i_last_grant == OWN_DATA) ? OWN_INST : OWN_DATA;
    end else if (i_data_req) begin
      o_grant_owner = OWN_DATA;
    end
`else
    if (i_data_req) begin
      o_grant_owner = OWN_DATA;
    end
`endif
  end

endmodule

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
// Purpose : Shares one SRAM-like port between an instruction-fetch requester
//           and a load/store requester. At most one transaction is outstanding;
//           each transaction walks IDLE -> ADDR -> DATA -> IDLE.
// Config  : SRAM_ARB_RR_EN - when defined, simultaneous requests are resolved
//           round-robin using a last-grant register; otherwise data has fixed
//           priority over inst and no last-grant register exists.
// Ports   : clk, resetn (async, active-low)
//           inst_req/inst_addr           -> inst_addr_ok/inst_data_ok/inst_rdata
//           data_req/data_wstrb/data_addr/data_wdata
//                                        -> data_addr_ok/data_data_ok/data_rdata
//           mem_req/mem_wstrb/mem_addr/mem_wdata <- mem_addr_ok/mem_data_ok/mem_rdata
// -----------------------------------------------------------------------------
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          inst_req,
  input  logic [AW-1:0] inst_addr,
  output logic          inst_addr_ok,
  output logic          inst_data_ok,
  output logic [31:0]   inst_rdata,
  input  logic          data_req,
  input  logic [3:0]    data_wstrb,
  input  logic [AW-1:0] data_addr,
  input  logic [31:0]   data_wdata,
  output logic          data_addr_ok,
  output logic          data_data_ok,
  output logic [31:0]   data_rdata,
  output logic          mem_req,
  output logic [3:0]    mem_wstrb,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_addr_ok,
  input  logic          mem_data_ok,
  input  logic [31:0]   mem_rdata
);

  state_t        r_state;
  state_t        w_next_state;
  logic          r_owner;
  logic [AW-1:0] r_addr;
  logic [3:0]    r_wstrb;
  logic [31:0]   r_wdata;

  logic          w_grant_vld;
  logic          w_grant_owner;
  logic          w_grant;

`ifdef SRAM_ARB_RR_EN
  logic          r_last_grant;
`endif

  sram_arb_pick u_pick (
    .i_inst_req    (inst_req),
    .i_data_req    (data_req),
`ifdef SRAM_ARB_RR_EN
    .i_last_grant  (r_last_grant),
`endif
    .o_grant_vld   (w_grant_vld),
    .o_grant_owner (w_grant_owner)
  );

  // Read data is a straight pass-through; only the owner's data_ok qualifies it.
  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;
  assign mem_wstrb  = r_wstrb;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;

  // Handshake outputs are also gated by resetn so they drop the moment reset
  // asserts, without waiting for the state register to settle.
  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    mem_req      = 1'b0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (resetn && w_grant_vld) begin
          w_grant      = 1'b1;
          inst_addr_ok = (w_grant_owner == OWN_INST);
          data_addr_ok = (w_grant_owner == OWN_DATA);
          w_next_state = ST_ADDR;
        end
      end
      ST_ADDR: begin
        mem_req = resetn;
        if (mem_addr_ok) begin
          w_next_state = ST_DATA;
        end
      end
      ST_DATA: begin
        if (resetn && mem_data_ok) begin
          inst_data_ok = (r_owner == OWN_INST);
          data_data_ok = (r_owner == OWN_DATA);
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State and latched request fields
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_owner <= OWN_INST;
      r_addr  <= '0;
      r_wstrb <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_grant) begin
        r_owner <= w_grant_owner;
        if (w_grant_owner == OWN_DATA) begin
          r_addr  <= data_addr;
          r_wstrb <= data_wstrb;
          r_wdata <= data_wdata;
        end else begin
          r_addr  <= inst_addr;
          r_wstrb <= 4'b0000;
          r_wdata <= 32'h0000_0000;
        end
      end
    end
  end

`ifdef SRAM_ARB_RR_EN
  // Last-grant history for round-robin
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last_grant <= OWN_INST;
    end else if (w_grant) begin
      r_last_grant <= w_grant_owner;
    end
  end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  sram_arbiter #(.AW(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_req      (mem_req),
    .mem_wstrb    (mem_wstrb),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change #1 after a rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // One transaction with both requesters held high the whole time.
  task automatic both_txn(input int idx, output logic got_data);
    inst_req = 1'b1;
    data_req = 1'b1;
    sample();
    chk($sformatf("rr%0d_one_grant", idx), {31'd0, inst_addr_ok ^ data_addr_ok}, 32'd1);
    got_data = data_addr_ok;
    next_cycle();
    mem_addr_ok = 1'b1;
    sample();
    chk($sformatf("rr%0d_addr_no_aok", idx), {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
    next_cycle();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h0000_1000 + idx;
    sample();
    chk($sformatf("rr%0d_dok", idx), {30'd0, inst_data_ok, data_data_ok},
        got_data ? 32'd1 : 32'd2);
    chk($sformatf("rr%0d_data_no_aok", idx), {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
    next_cycle();
    mem_data_ok = 1'b0;
  endtask

  initial begin
    logic got_data;
    logic exp_data [4];

    resetn      = 1'b0;
    inst_req    = 1'b1;
    inst_addr   = 32'h0;
    data_req    = 1'b1;
    data_wstrb  = 4'h0;
    data_addr   = 32'h0;
    data_wdata  = 32'h0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h0;

    // Reset state with requests and a stray mem_data_ok present
    repeat (2) next_cycle();
    sample();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
    chk("rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    next_cycle();
    inst_req    = 1'b0;
    data_req    = 1'b0;
    mem_data_ok = 1'b0;
    resetn      = 1'b1;
    next_cycle();

    // Single fetch
    inst_req  = 1'b1;
    inst_addr = 32'hBFC0_0000;
    sample();
    chk("f_inst_aok", {31'd0, inst_addr_ok}, 32'd1);
    chk("f_data_aok", {31'd0, data_addr_ok}, 32'd0);
    chk("f_idle_mem_req", {31'd0, mem_req}, 32'd0);
    next_cycle();
    inst_req    = 1'b0;
    inst_addr   = 32'h1234_5678;
    mem_addr_ok = 1'b1;
    sample();
    chk("f_mem_req", {31'd0, mem_req}, 32'd1);
    chk("f_mem_addr", mem_addr, 32'hBFC0_0000);
    chk("f_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    next_cycle();
    mem_addr_ok = 1'b0;
    sample();
    chk("f_data_wait_req", {31'd0, mem_req}, 32'd0);
    chk("f_data_wait_dok", {31'd0, inst_data_ok}, 32'd0);
    next_cycle();
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h3C1D_0001;
    sample();
    chk("f_inst_dok", {31'd0, inst_data_ok}, 32'd1);
    chk("f_inst_rdata", inst_rdata, 32'h3C1D_0001);
    chk("f_data_dok", {31'd0, data_data_ok}, 32'd0);
    next_cycle();
    mem_data_ok = 1'b0;
    sample();
    chk("f_dok_once", {31'd0, inst_data_ok}, 32'd0);
    chk("f_back_idle", {31'd0, mem_req}, 32'd0);
    next_cycle();

    // Simultaneous requests: data wins, inst waits for data_data_ok
    inst_req   = 1'b1;
    inst_addr  = 32'hBFC0_0004;
    data_req   = 1'b1;
    data_wstrb = 4'h0;
    data_addr  = 32'h8000_0000;
    sample();
    chk("p_data_aok", {31'd0, data_addr_ok}, 32'd1);
    chk("p_inst_aok", {31'd0, inst_addr_ok}, 32'd0);
    next_cycle();
    data_req    = 1'b0;
    mem_addr_ok = 1'b1;
    sample();
    chk("p_addr_inst_aok", {31'd0, inst_addr_ok}, 32'd0);
    chk("p_mem_addr", mem_addr, 32'h8000_0000);
    next_cycle();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h1111_2222;
    sample();
    chk("p_data_dok", {31'd0, data_data_ok}, 32'd1);
    chk("p_data_rdata", data_rdata, 32'h1111_2222);
    chk("p_inst_dok", {31'd0, inst_data_ok}, 32'd0);
    chk("p_data_inst_aok", {31'd0, inst_addr_ok}, 32'd0);
    next_cycle();
    mem_data_ok = 1'b0;
    sample();
    chk("p_inst_granted", {31'd0, inst_addr_ok}, 32'd1);
    next_cycle();
    inst_req    = 1'b0;
    mem_data_ok = 1'b1;  // stray response in ADDR must be ignored
    mem_rdata   = 32'hBAD0_BAD0;
    sample();
    chk("p_addr_ignore_dok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    chk("p_mem_addr2", mem_addr, 32'hBFC0_0004);
    next_cycle();
    mem_data_ok = 1'b0;
    mem_addr_ok = 1'b1;
    next_cycle();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'hCAFE_F00D;
    sample();
    chk("p_inst_dok2", {31'd0, inst_data_ok}, 32'd1);
    chk("p_inst_rdata2", inst_rdata, 32'hCAFE_F00D);
    next_cycle();
    mem_data_ok = 1'b0;

    // Back-to-back contention: alternating with round-robin, data every time otherwise
`ifdef SRAM_ARB_RR_EN
    exp_data[0] = 1'b1; exp_data[1] = 1'b0; exp_data[2] = 1'b1; exp_data[3] = 1'b0;
`else
    exp_data[0] = 1'b1; exp_data[1] = 1'b1; exp_data[2] = 1'b1; exp_data[3] = 1'b1;
`endif
    for (int i = 0; i < 4; i++) begin
      both_txn(i, got_data);
      chk($sformatf("rr%0d_winner_is_data", i), {31'd0, got_data}, {31'd0, exp_data[i]});
    end
    inst_req = 1'b0;
    data_req = 1'b0;
    next_cycle();

    // Store with a slow address handshake
    data_req   = 1'b1;
    data_wstrb = 4'b0011;
    data_addr  = 32'h8000_0010;
    data_wdata = 32'hDEAD_BEEF;
    sample();
    chk("s_data_aok", {31'd0, data_addr_ok}, 32'd1);
    next_cycle();
    data_req   = 1'b0;
    data_wstrb = 4'b1111;
    data_addr  = 32'h0000_0000;
    data_wdata = 32'h0000_0000;
    for (int c = 0; c < 5; c++) begin
      sample();
      chk($sformatf("s_hold%0d_req", c), {31'd0, mem_req}, 32'd1);
      chk($sformatf("s_hold%0d_addr", c), mem_addr, 32'h8000_0010);
      chk($sformatf("s_hold%0d_wstrb", c), {28'd0, mem_wstrb}, 32'd3);
      chk($sformatf("s_hold%0d_wdata", c), mem_wdata, 32'hDEAD_BEEF);
      next_cycle();
    end
    mem_addr_ok = 1'b1;
    sample();
    chk("s_accept_req", {31'd0, mem_req}, 32'd1);
    next_cycle();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    sample();
    chk("s_data_dok", {31'd0, data_data_ok}, 32'd1);
    chk("s_inst_dok", {31'd0, inst_data_ok}, 32'd0);
    next_cycle();
    mem_data_ok = 1'b0;
    sample();
    chk("s_dok_once", {31'd0, data_data_ok}, 32'd0);
    next_cycle();

    // Reset during ADDR drops mem_req at once
    inst_req  = 1'b1;
    inst_addr = 32'hBFC0_0100;
    next_cycle();
    inst_req = 1'b0;
    #2;
    chk("ra_pre_req", {31'd0, mem_req}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("ra_mem_req", {31'd0, mem_req}, 32'd0);
    chk("ra_mem_addr", mem_addr, 32'h0);
    next_cycle();
    resetn = 1'b1;
    next_cycle();

    // Reset during DATA, late response afterwards is ignored
    inst_req  = 1'b1;
    inst_addr = 32'hBFC0_0200;
    next_cycle();
    inst_req    = 1'b0;
    mem_addr_ok = 1'b1;
    next_cycle();
    mem_addr_ok = 1'b0;
    #2;
    resetn      = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h5555_AAAA;
    #1;
    chk("rd_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rd_dok_in_rst", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    next_cycle();
    resetn = 1'b1;
    sample();
    chk("rd_late_dok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    chk("rd_late_req", {31'd0, mem_req}, 32'd0);
    next_cycle();
    sample();
    chk("rd_late_dok2", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    next_cycle();
    mem_data_ok = 1'b0;

    // Arbiter still serves a load after the abandoned transaction
    data_req   = 1'b1;
    data_wstrb = 4'h0;
    data_addr  = 32'h8000_0020;
    sample();
    chk("post_data_aok", {31'd0, data_addr_ok}, 32'd1);
    next_cycle();
    data_req    = 1'b0;
    mem_addr_ok = 1'b1;
    sample();
    chk("post_mem_addr", mem_addr, 32'h8000_0020);
    next_cycle();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h0BAD_CAFE;
    sample();
    chk("post_data_dok", {31'd0, data_data_ok}, 32'd1);
    chk("post_data_rdata", data_rdata, 32'h0BAD_CAFE);
    next_cycle();
    mem_data_ok = 1'b0;
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
